rv32i_instr_encoder: RTL
========================

Name: rv32i_instr_encoder

Overview:
Sequential RV32I instruction encoder, the inverse of the decode-stage control unit. It accepts decoded instruction fields (class, funct3, alt bit, register indices, immediate) over a valid/ready handshake. It validates the fields against the subset the control unit decodes, packs them into a 32-bit instruction word, and streams the word with a word address toward instruction-memory load logic. Used by the boot loader and the test harness to fill instruction memory.

Parameters:
ADDR_W, 10, width of the word address and the address counter
BASE_ADDR, 0, first word address issued after reset or start
DEPTH, 2, output buffer entries (power of two, ≥2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: flush buffer, counter := BASE_ADDR, clear sticky errors
in_valid  in  1  field set valid
in_ready  out  1  encoder can accept
in_kind  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9-15 reserved
in_funct3  in  3  funct3
in_alt  in  1  funct7[5] (SUB/SRA/SRAI)
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_imm  in  32  signed byte-offset immediate; for U-type, the final value with imm[11:0]=0
out_valid  out  1  buffer head valid
out_ready  in  1  consumer takes head
out_instr  out  32  encoded word
out_addr  out  ADDR_W  word address of out_instr
err_illegal  out  1  sticky: illegal field set dropped
err_range  out  1  sticky: address space exhausted
count  out  ADDR_W+1  words issued since reset/start

Behaviour:
- Reset (async) and start (sync): buffer empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, counter=BASE_ADDR, count=0, err_illegal=0, err_range=0.
- in_ready = !start && (buffer not full || out_ready). Acceptance occurs on in_valid && in_ready at a rising clk edge.
- Latency: an accepted legal word appears at the buffer tail on the next edge, so out_valid rises 1 cycle after acceptance into an empty buffer. Enqueue and dequeue in the same cycle when full are allowed.
- Opcodes: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- Legality: R: alt=0 any funct3; alt=1 only 000/101. I-ALU: alt=1 only with funct3 101; for 001/101, instr[31:25]={0,alt,00000} and instr[24:20]=imm[4:0]. STORE: funct3 000-010. BRANCH: funct3 not 010/011. LOAD: 000,001,010,100,101. JALR: funct3 000. Kinds 9-15 are illegal. Fields not used by a format are ignored.
- Immediate packing follows standard I/S/B/U/J bit scatter. B and J use imm bits [12:1] and [20:1].
- Illegal input: still accepted (handshake completes), but dropped. err_illegal is set; counter and count are unchanged.
- Each legal word takes address=counter; then counter+1 and count+1.
- When count reaches 2^ADDR_W, further legal inputs are accepted and dropped, and err_range is set. The counter does not wrap.
- start concurrent with in_valid: start wins, nothing is accepted. Reset mid-stream discards buffered words.

Optional Feature:
ENC_IMM_CHECK_EN
- Defined: an immediate outside its format range is illegal (dropped, err_illegal=1). This covers I/S/L/JALR outside -2048..2047, an odd value or outside ±4096 for B, an odd value or outside ±1 MiB for J, and imm[11:0]≠0 for U.
- Undefined: the immediate is silently truncated to the format bits, with no error.

Test Plan:
- addi x1,x0,5 (kind1,f3 000,imm 5,rd 1), out_ready=1 -> out_instr=0x00500093, out_addr=0, out_valid 1 cycle after accept, count=1.
- add x3,x1,x2, then sub (alt=1) -> 0x002081B3 at addr 1, then 0x402081B3 at addr 2.
- beq x1,x2,+8 -> 0x00208463; lui x5,0x12345000 -> 0x123452B7; jal x1,+16 -> 0x010000EF. Addresses are consecutive.
- out_ready=0, drive 3 legal inputs -> 2 accepted, in_ready=0. Raise out_ready -> words drain in order, third is accepted, no loss or duplication.
- kind 0 alt=1 f3 001, then kind 12 -> both accepted, dropped, err_illegal=1, count unchanged. start -> err_illegal=0, next word at BASE_ADDR.
- ADDR_W=2: issue 5 legal words -> addrs 0-3 emitted, fifth dropped, err_range=1. With ENC_IMM_CHECK_EN, addi imm 4096 -> err_illegal=1.

Source files
------------

// File: rtl/rv32i_instr_encoder_if.sv
// Field-set / word-stream bus of the RV32I instruction encoder.
// master: producer of decoded fields and consumer of encoded words.
// slave : the encoder.
interface rv32i_instr_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [2:0]        in_funct3;
    logic              in_alt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: validates decoded fields, packs them into a
// 32-bit instruction word and streams (word, address) through a small FIFO.
// Optional macro ENC_IMM_CHECK_EN: out-of-range immediates are treated as
// illegal instead of being silently truncated to the format bits.
module rv32i_instr_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    rv32i_instr_encoder_if.slave bus,
    output logic                 err_illegal,
    output logic                 err_range,
    output logic [ADDR_W:0]      count
);
    localparam int unsigned       PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       LVL_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        KIND_R      = 4'd0,
        KIND_I      = 4'd1,
        KIND_LOAD   = 4'd2,
        KIND_STORE  = 4'd3,
        KIND_BRANCH = 4'd4,
        KIND_LUI    = 4'd5,
        KIND_AUIPC  = 4'd6,
        KIND_JAL    = 4'd7,
        KIND_JALR   = 4'd8
    } kind_e;

`ifdef ENC_IMM_CHECK_EN
    // True when v is representable as an n-bit two's-complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
        logic [31:0] s;
        s = $unsigned($signed(v) >>> (n - 1));
        return (s == '0) || (s == '1);
    endfunction
`else
    logic w_unused_imm_lsb;
    assign w_unused_imm_lsb = bus.in_imm[0];
`endif

    kind_e             w_kind;
    logic [2:0]        w_f3;
    logic              w_alt;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [31:0]       w_imm;
    logic [31:0]       w_instr;
    logic              w_fmt_ok;
    logic              w_imm_ok;
    logic              w_legal;

    logic [31:0]       r_mem_instr [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [ADDR_W-1:0] r_counter;
    logic              r_addr_done;
    logic              r_err_illegal;
    logic              r_err_range;
    logic [ADDR_W:0]   r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_exhausted;
    logic              w_push;
    logic              w_pop;

    assign w_kind = kind_e'(bus.in_kind);
    assign w_f3   = bus.in_funct3;
    assign w_alt  = bus.in_alt;
    assign w_rd   = bus.in_rd;
    assign w_rs1  = bus.in_rs1;
    assign w_rs2  = bus.in_rs2;
    assign w_imm  = bus.in_imm;

    // Field legality check and instruction packing per format.
    always_comb begin
        w_instr  = '0;
        w_fmt_ok = 1'b0;
        w_imm_ok = 1'b1;
        case (w_kind)
            KIND_R: begin
                w_fmt_ok = !w_alt || (w_f3 == 3'b000) || (w_f3 == 3'b101);
                w_instr  = {1'b0, w_alt, 5'b00000, w_rs2, w_rs1, w_f3, w_rd, OP_R};
            end
            KIND_I: begin
                w_fmt_ok = !w_alt || (w_f3 == 3'b101);
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
                    w_instr = {1'b0, w_alt, 5'b00000, w_imm[4:0], w_rs1, w_f3, w_rd, OP_I};
                end else begin
                    w_instr = {w_imm[11:0], w_rs1, w_f3, w_rd, OP_I};
                end
`ifdef ENC_IMM_CHECK_EN
                w_imm_ok = fits_signed(w_imm, 12);
`endif
            end
            KIND_LOAD: begin
                w_fmt_ok = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
                w_instr  = {w_imm[11:0], w_rs1, w_f3, w_rd, OP_LOAD};
`ifdef ENC_IMM_CHECK_EN
                w_imm_ok = fits_signed(w_imm, 12);
`endif
            end
            KIND_STORE: begin
                w_fmt_ok = (w_f3 <= 3'b010);
                w_instr  = {w_imm[11:5], w_rs2, w_rs1, w_f3, w_imm[4:0], OP_STORE};
`ifdef ENC_IMM_CHECK_EN
                w_imm_ok = fits_signed(w_imm, 12);
`endif
            end
            KIND_BRANCH: begin
                w_fmt_ok = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_instr  = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_f3,
                            w_imm[4:1], w_imm[11], OP_BRANCH};
`ifdef ENC_IMM_CHECK_EN
                w_imm_ok = fits_signed(w_imm, 13) && !w_imm[0];
`endif
            end
            KIND_LUI: begin
                w_fmt_ok = 1'b1;
                w_instr  = {w_imm[31:12], w_rd, OP_LUI};
`ifdef ENC_IMM_CHECK_EN
                w_imm_ok = (w_imm[11:0] == '0);
`endif
            end
            KIND_AUIPC: begin
                w_fmt_ok = 1'b1;
                w_instr  = {w_imm[31:12], w_rd, OP_AUIPC};
`ifdef ENC_IMM_CHECK_EN
                w_imm_ok = (w_imm[11:0] == '0);
`endif
            end
            KIND_JAL: begin
                w_fmt_ok = 1'b1;
                w_instr  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, OP_JAL};
`ifdef ENC_IMM_CHECK_EN
                w_imm_ok = fits_signed(w_imm, 21) && !w_imm[0];
`endif
            end
            KIND_JALR: begin
                w_fmt_ok = (w_f3 == 3'b000);
                w_instr  = {w_imm[11:0], w_rs1, 3'b000, w_rd, OP_JALR};
`ifdef ENC_IMM_CHECK_EN
                w_imm_ok = fits_signed(w_imm, 12);
`endif
            end
            default: begin
                w_fmt_ok = 1'b0;
                w_instr  = '0;
            end
        endcase
    end

    assign w_legal = w_fmt_ok && w_imm_ok;

    // Exhaustion also covers a non-zero BASE_ADDR reaching the top address
    // before count hits 2^ADDR_W, so the counter never wraps.
    assign w_full      = (r_level == LVL_W'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_in_ready  = !start && (!w_full || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_exhausted = r_count[ADDR_W] || r_addr_done;
    assign w_push      = w_accept && w_legal && !w_exhausted;
    assign w_pop       = !w_empty && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = !w_empty;
    assign bus.out_instr = w_empty ? '0 : r_mem_instr[r_rd_ptr];
    assign bus.out_addr  = w_empty ? BASE : r_mem_addr[r_rd_ptr];
    assign err_illegal   = r_err_illegal;
    assign err_range     = r_err_range;
    assign count         = r_count;

    // FIFO storage write; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= w_instr;
            r_mem_addr[r_wr_ptr]  <= r_counter;
        end
    end

    // FIFO pointers, address counter, word count and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_counter     <= BASE;
            r_addr_done   <= 1'b0;
            r_count       <= '0;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else if (start) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_counter     <= BASE;
            r_addr_done   <= 1'b0;
            r_count       <= '0;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_count  <= r_count + (ADDR_W + 1)'(1);
                if (r_counter == '1) begin
                    r_addr_done <= 1'b1;
                end else begin
                    r_counter <= r_counter + ADDR_W'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_accept && !w_legal) begin
                r_err_illegal <= 1'b1;
            end
            if (w_accept && w_legal && w_exhausted) begin
                r_err_range <= 1'b1;
            end
        end
    end
endmodule
